// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped instruction cache for the fetch stage.
// Hits are served combinationally; a miss fills one whole line via req/ack and data beats.
module icache_fetch #(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINES          = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ReqF,
  input  logic [ADDR_WIDTH-1:0] AddrF,
  input  logic                  Invalidate,
  output logic [WORD_SIZE-1:0]  InstrF,
  output logic                  HitF,
  output logic                  CStall,
  output logic                  MemReq,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemAck,
  input  logic                  MemValid,
  input  logic [WORD_SIZE-1:0]  MemData
);

  localparam int OffW = $clog2(WORDS_PER_LINE);
  localparam int IdxW = $clog2(LINES);
  localparam int LowW = OffW + 2;
  localparam int TagW = ADDR_WIDTH - IdxW - LowW;
  localparam logic [OffW-1:0] LastBeat = OffW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } state_t;

  state_t state;

  logic [WORD_SIZE-1:0] dataArr [LINES][WORDS_PER_LINE];
  logic [TagW-1:0]      tagArr  [LINES];
  logic [LINES-1:0]     valid;

  logic [OffW-1:0] beatCnt;
  logic [IdxW-1:0] fillIdx;
  logic [TagW-1:0] fillTag;
  logic            invPend;

  logic [OffW-1:0] offset;
  logic [IdxW-1:0] index;
  logic [TagW-1:0] tag;
  logic            unusedAddr;

  assign offset     = AddrF[LowW-1:2];
  assign index      = AddrF[LowW+IdxW-1:LowW];
  assign tag        = AddrF[ADDR_WIDTH-1:LowW+IdxW];
  assign unusedAddr = ^AddrF[1:0];

  // Combinational lookup against the current valid/tag state
  always_comb begin
    HitF   = ReqF && (state == IDLE)
             && valid[index] && (tagArr[index] == tag);
    InstrF = HitF ? dataArr[index][offset] : '0;
    CStall = (ReqF && !HitF) || (state != IDLE);
  end

  // Line storage written one beat at a time; tag lands with the last beat
  always_ff @(posedge clk) begin
    if (state == FILL && MemValid) begin
      dataArr[fillIdx][beatCnt] <= MemData;
      if (beatCnt == LastBeat) begin
        tagArr[fillIdx] <= fillTag;
      end
    end
  end

  // Miss handling: request the line, collect beats, then validate it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid   <= '0;
      MemReq  <= 1'b0;
      MemAddr <= '0;
      beatCnt <= '0;
      fillIdx <= '0;
      fillTag <= '0;
      invPend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Invalidate) begin
            valid <= '0;
          end
          if (ReqF && !HitF) begin
            fillIdx        <= index;
            fillTag        <= tag;
            valid[index]   <= 1'b0;
            MemAddr        <= {tag, index, {LowW{1'b0}}};
            MemReq         <= 1'b1;
            state          <= REQ;
          end
        end
        REQ: begin
          if (Invalidate) begin
            invPend <= 1'b1;
          end
          if (MemAck) begin
            MemReq  <= 1'b0;
            beatCnt <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (Invalidate) begin
            invPend <= 1'b1;
          end
          if (MemValid) begin
            beatCnt <= beatCnt + 1'b1;
            if (beatCnt == LastBeat) begin
              state   <= IDLE;
              invPend <= 1'b0;
              if (invPend || Invalidate) begin
                valid <= '0;
              end else begin
                valid[fillIdx] <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
